// File: rtl/cond_update_pkg.sv
// Shared types and width helpers for the conditional-update pipeline.
// Rule structs are declared per module because their width follows WIDTH.
package cond_update_pkg;

  typedef enum logic {
    OP_REPLACE = 1'b0,
    OP_ADD     = 1'b1
  } rule_op_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Packed rule layout: {en, op, key, val}
  function automatic int rule_w(input int w);
    return 2 * w + 2;
  endfunction

endpackage

// File: rtl/cond_update_if.sv
// Producer/consumer handshake bundle for cond_update_pipe.
// master drives inputs and consumes outputs; slave is the pipeline side.
interface cond_update_if
  import cond_update_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_RULES = 4
);
  localparam int IDX_W = idx_w(NUM_RULES);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_hit;
  logic [IDX_W-1:0] out_rule;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data,
    input  out_hit, out_rule
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data,
    output out_hit, out_rule
  );

endinterface

// File: rtl/cond_update_pipe_match.sv
// Combinational priority scan: lowest enabled rule whose key equals
// the sum wins and either replaces it or adds its operand.
module cond_rule_match
  import cond_update_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_RULES = 4,
  localparam int IDX_W    = idx_w(NUM_RULES),
  localparam int RULE_W   = rule_w(WIDTH)
) (
  input  logic [WIDTH-1:0]            i_sum,
  input  logic [NUM_RULES*RULE_W-1:0] i_rules,
  output logic                        o_hit,
  output logic [IDX_W-1:0]            o_idx,
  output logic [WIDTH-1:0]            o_result
);

  typedef struct packed {
    logic             en;
    rule_op_t         op;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] val;
  } rule_t;

  rule_t [NUM_RULES-1:0] w_rules;

  assign w_rules = i_rules;

  // Scan high to low so the lowest matching index is applied last.
  always_comb begin
    o_hit    = 1'b0;
    o_idx    = '0;
    o_result = i_sum;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (w_rules[i].en && (w_rules[i].key == i_sum)) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
        if (w_rules[i].op == OP_ADD)
          o_result = i_sum + w_rules[i].val;
        else
          o_result = w_rules[i].val;
      end
    end
  end

endmodule

// File: rtl/cond_update_pipe.sv
// Two-stage accumulate-then-rule pipeline with valid/ready on both
// sides and a runtime-programmable rule table.
module cond_update_pipe
  import cond_update_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NUM_RULES = 4,
  localparam int IDX_W    = idx_w(NUM_RULES)
) (
  input  logic             clk,
  input  logic             rst,
  cond_update_if.slave     bus,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic             cfg_en,
  input  logic             cfg_op,
  input  logic [WIDTH-1:0] cfg_key,
  input  logic [WIDTH-1:0] cfg_val,
  output logic [WIDTH-1:0] acc_value
);

  typedef struct packed {
    logic             en;
    rule_op_t         op;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] val;
  } rule_t;

  rule_t [NUM_RULES-1:0] r_rules;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_hit;
  logic [IDX_W-1:0] r_out_rule;

  logic             w_s2_fire;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_sum;
  logic             w_hit;
  logic [IDX_W-1:0] w_idx;
  logic [WIDTH-1:0] w_result;

  assign w_s2_fire    = r_s1_valid && (!r_out_valid || bus.out_ready);
  assign bus.in_ready = !r_s1_valid || w_s2_fire;
  assign w_in_fire    = bus.in_valid && bus.in_ready;
  assign w_sum        = r_acc + r_s1_data;

  cond_rule_match #(
    .WIDTH     (WIDTH),
    .NUM_RULES (NUM_RULES)
  ) u_match (
    .i_sum    (w_sum),
    .i_rules  (r_rules),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_result (w_result)
  );

  // Out-of-range indices match no slot and are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rules <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_idx == IDX_W'(i)) begin
          r_rules[i] <= '{en:  cfg_en,
                          op:  rule_op_t'(cfg_op),
                          key: cfg_key,
                          val: cfg_val};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_data  <= bus.in_data;
    end else if (w_s2_fire) begin
      r_s1_valid <= 1'b0;
    end
  end

  // acc only moves on S2 fire, so S1 always sees the settled value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_hit   <= 1'b0;
      r_out_rule  <= '0;
    end else if (w_s2_fire) begin
      r_acc       <= w_result;
      r_out_valid <= 1'b1;
      r_out_data  <= w_result;
      r_out_hit   <= w_hit;
      r_out_rule  <= w_idx;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_hit   = r_out_hit;
  assign bus.out_rule  = r_out_rule;
  assign acc_value     = r_acc;

endmodule
